// File: rtl/rat_io_ctrl.sv
// RAT MCU port-bus controller: synchronised inputs, strobed outputs,
// atomic 16-bit seven-segment register and masked edge interrupts.
module rat_io_ctrl #(
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 2,
    parameter logic [7:0]  IN_BASE     = 8'h20,
    parameter logic [7:0]  OUT_BASE    = 8'h40,
    parameter logic [7:0]  SS_LO_ID    = 8'h81,
    parameter logic [7:0]  SS_HI_ID    = 8'h82,
    parameter logic [7:0]  INT_MASK_ID = 8'hF0,
    parameter logic [7:0]  INT_ACK_ID  = 8'hF1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [7:0]           PORT_ID,
    input  logic [7:0]           OUT_PORT,
    input  logic                 IO_STRB,
    output logic [7:0]           IN_PORT,
    input  logic [8*N_IN-1:0]    IN_PINS,
    output logic [8*N_OUT-1:0]   OUT_REGS,
    output logic [15:0]          SEVSEG,
    output logic                 INTR
);

    logic [8*N_IN-1:0] sync_a;
    logic [8*N_IN-1:0] sync_b;
    logic [7:0]        hi_stage;
    logic [7:0]        mask;
    logic [7:0]        pending;
    logic [7:0]        hist;
    logic [7:0]        rise;
    logic [7:0]        ack_clr;
    logic [1:0]        arm_cnt;
    logic              armed;
    logic              wr_mask;
    logic              wr_ack;
    logic              wr_hi;
    logic              wr_lo;

    always_comb begin
        armed   = (arm_cnt == 2'd0);
        wr_mask = IO_STRB && (PORT_ID == INT_MASK_ID);
        wr_ack  = IO_STRB && (PORT_ID == INT_ACK_ID);
        wr_hi   = IO_STRB && (PORT_ID == SS_HI_ID);
        wr_lo   = IO_STRB && (PORT_ID == SS_LO_ID);
        rise    = sync_b[7:0] & ~hist & mask & {8{armed}};
        ack_clr = wr_ack ? OUT_PORT : 8'h00;
    end

    // Read mux; address ranges are disjoint so no priority is implied.
    always_comb begin
        IN_PORT = 8'h00;
        for (int k = 0; k < N_IN; k++) begin
            if (PORT_ID == IN_BASE + 8'(k))
                IN_PORT = sync_b[8*k +: 8];
        end
        if (PORT_ID == INT_ACK_ID)
            IN_PORT = pending;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync_a   <= '0;
            sync_b   <= '0;
            hist     <= 8'h00;
            mask     <= 8'h00;
            pending  <= 8'h00;
            hi_stage <= 8'h00;
            SEVSEG   <= 16'h0000;
            OUT_REGS <= '0;
            INTR     <= 1'b0;
            arm_cnt  <= 2'd3;
        end else begin
            sync_a  <= IN_PINS;
            sync_b  <= sync_a;
            hist    <= sync_b[7:0];
            // Edge wins over a same-cycle acknowledge.
            pending <= (pending & ~ack_clr) | rise;
            INTR    <= |pending;
            if (!armed)
                arm_cnt <= arm_cnt - 2'd1;
            if (wr_mask)
                mask <= OUT_PORT;
            if (wr_hi)
                hi_stage <= OUT_PORT;
            if (wr_lo)
                SEVSEG <= {hi_stage, OUT_PORT};
            for (int k = 0; k < N_OUT; k++) begin
                if (IO_STRB && (PORT_ID == OUT_BASE + 8'(k)))
                    OUT_REGS[8*k +: 8] <= OUT_PORT;
            end
        end
    end

endmodule

// File: tb/tb_rat_io_ctrl.sv
// Bench for rat_io_ctrl: directed scenarios plus random bus traffic
// checked against a cycle-level behavioural model.
module tb_rat_io_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  PORT_ID;
    logic [7:0]  OUT_PORT;
    logic        IO_STRB;
    logic [7:0]  IN_PORT;
    logic [15:0] IN_PINS;
    logic [15:0] OUT_REGS;
    logic [15:0] SEVSEG;
    logic        INTR;

    always #5 CLK = ~CLK;

    rat_io_ctrl dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .IN_PORT  (IN_PORT),
        .IN_PINS  (IN_PINS),
        .OUT_REGS (OUT_REGS),
        .SEVSEG   (SEVSEG),
        .INTR     (INTR)
    );

    int errs   = 0;
    int checks = 0;

    // Reference model state
    logic [7:0]  m_out [2];
    logic [15:0] m_ss;
    logic [7:0]  m_hi;
    logic [7:0]  m_mask;
    logic [7:0]  m_pend;
    logic [7:0]  m_hist;
    logic        m_intr;
    logic [15:0] m_pins [$];
    int          m_age;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        m_out[0] = 8'h00;
        m_out[1] = 8'h00;
        m_ss     = 16'h0000;
        m_hi     = 8'h00;
        m_mask   = 8'h00;
        m_pend   = 8'h00;
        m_hist   = 8'h00;
        m_intr   = 1'b0;
        m_pins   = '{16'h0000, 16'h0000};
        m_age    = 0;
    endtask

    // Pins are visible two edges after they are sampled.
    function automatic logic [7:0] m_read(input logic [7:0] id);
        logic [15:0] syn;
        syn = m_pins[1];
        if (id == 8'h20) return syn[7:0];
        if (id == 8'h21) return syn[15:8];
        if (id == 8'hF1) return m_pend;
        return 8'h00;
    endfunction

    task automatic model_edge();
        logic [15:0] syn;
        logic [7:0]  syn0;
        logic [7:0]  rise;
        logic [7:0]  ack;
        if (!RESET_N) begin
            m_clear();
        end else begin
            syn  = m_pins[1];
            syn0 = syn[7:0];
            rise = syn0 & ~m_hist & m_mask & ((m_age >= 3) ? 8'hFF : 8'h00);
            ack  = (IO_STRB && PORT_ID == 8'hF1) ? OUT_PORT : 8'h00;
            m_intr = |m_pend;
            m_pend = (m_pend & ~ack) | rise;
            m_hist = syn0;
            if (IO_STRB) begin
                case (PORT_ID)
                    8'h40:   m_out[0] = OUT_PORT;
                    8'h41:   m_out[1] = OUT_PORT;
                    8'hF0:   m_mask   = OUT_PORT;
                    8'h82:   m_hi     = OUT_PORT;
                    8'h81:   m_ss     = {m_hi, OUT_PORT};
                    default: ;
                endcase
            end
            m_pins.push_front(IN_PINS);
            void'(m_pins.pop_back());
            m_age++;
        end
    endtask

    task automatic cycle();
        #1 chk("in_port", {24'h0, IN_PORT}, {24'h0, m_read(PORT_ID)});
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("out_regs", {16'h0, OUT_REGS}, {16'h0, m_out[1], m_out[0]});
        chk("sevseg", {16'h0, SEVSEG}, {16'h0, m_ss});
        chk("intr", {31'h0, INTR}, {31'h0, m_intr});
    endtask

    task automatic io(input logic [7:0] id, input logic [7:0] d,
                      input logic s);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = s;
        cycle();
    endtask

    task automatic idle(input int n);
        IO_STRB = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic rd(input string tag, input logic [7:0] id,
                      input logic [7:0] exp);
        PORT_ID = id;
        IO_STRB = 1'b0;
        #1 chk(tag, {24'h0, IN_PORT}, {24'h0, exp});
    endtask

    logic [7:0] ids [11] = '{8'h20, 8'h21, 8'h22, 8'h40, 8'h41, 8'h42,
                            8'h81, 8'h82, 8'hF0, 8'hF1, 8'h30};

    initial begin
        m_clear();
        RESET_N  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        IO_STRB  = 1'b0;
        IN_PINS  = 16'h0000;
        @(posedge CLK);
        @(negedge CLK);
        cycle();
        chk("rst_out", {16'h0, OUT_REGS}, 32'h0);
        chk("rst_ss", {16'h0, SEVSEG}, 32'h0);
        chk("rst_intr", {31'h0, INTR}, 32'h0);
        RESET_N = 1'b1;

        io(8'h41, 8'hA5, 1'b1);
        chk("out_wr", {16'h0, OUT_REGS}, 32'h0000A500);
        io(8'h41, 8'hFF, 1'b0);
        chk("out_nostrb", {16'h0, OUT_REGS}, 32'h0000A500);

        io(8'h82, 8'h12, 1'b1);
        chk("ss_hi_only", {16'h0, SEVSEG}, 32'h0);
        io(8'h81, 8'h34, 1'b1);
        chk("ss_commit", {16'h0, SEVSEG}, 32'h1234);
        io(8'h81, 8'h56, 1'b1);
        chk("ss_reuse_hi", {16'h0, SEVSEG}, 32'h1256);

        IN_PINS = 16'h3C00;
        PORT_ID = 8'h21;
        idle(1);
        rd("sync_1cyc", 8'h21, 8'h00);
        idle(1);
        rd("sync_2cyc", 8'h21, 8'h3C);
        rd("rd_unmapped", 8'h30, 8'h00);

        io(8'hF0, 8'h01, 1'b1);
        IN_PINS = 16'h3C01;
        idle(3);
        rd("pend_set", 8'hF1, 8'h01);
        chk("intr_lag", {31'h0, INTR}, 32'h0);
        idle(1);
        chk("intr_set", {31'h0, INTR}, 32'h1);
        io(8'hF1, 8'h01, 1'b1);
        idle(1);
        chk("intr_ack", {31'h0, INTR}, 32'h0);
        IN_PINS = 16'h3C03;
        idle(5);
        chk("intr_masked", {31'h0, INTR}, 32'h0);

        IN_PINS = 16'h3C02;
        idle(3);
        IN_PINS = 16'h3C03;
        idle(4);
        chk("intr_again", {31'h0, INTR}, 32'h1);
        IN_PINS = 16'h3C02;
        idle(3);
        IN_PINS = 16'h3C03;
        idle(2);
        io(8'hF1, 8'h01, 1'b1);
        rd("coinc_pend", 8'hF1, 8'h01);
        chk("coinc_intr", {31'h0, INTR}, 32'h1);
        idle(1);
        chk("coinc_intr2", {31'h0, INTR}, 32'h1);

        io(8'h81, 8'h77, 1'b1);
        chk("ss_pre_rst", {16'h0, SEVSEG}, 32'h1277);
        RESET_N = 1'b0;
        idle(1);
        chk("rst_intr_clr", {31'h0, INTR}, 32'h0);
        chk("rst_ss_clr", {16'h0, SEVSEG}, 32'h0);
        RESET_N = 1'b1;
        io(8'hF0, 8'h01, 1'b1);
        idle(6);
        chk("arm_no_intr", {31'h0, INTR}, 32'h0);
        rd("arm_no_pend", 8'hF1, 8'h00);
        IN_PINS = 16'h3C02;
        idle(3);
        IN_PINS = 16'h3C03;
        idle(4);
        chk("armed_intr", {31'h0, INTR}, 32'h1);
        RESET_N = 1'b0;
        idle(1);
        chk("rst2_intr", {31'h0, INTR}, 32'h0);
        chk("rst2_ss", {16'h0, SEVSEG}, 32'h0);
        RESET_N = 1'b1;

        for (int i = 0; i < 600; i++) begin
            RESET_N = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0)
                IN_PINS = 16'($urandom);
            io(ids[$urandom_range(0, 10)], 8'($urandom),
               1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
